// File: rtl/alu_exec.sv
// Execute stage feeding the 10x15 register file write port: single-cycle ALU ops plus
// an optional 15-iteration shift-add multiplier, enabled by defining ALUEXEC_MUL_EN.
module alu_exec #(
  parameter int DW   = 15,
  parameter int NREG = 10,
  parameter int AW   = 4
) (
  input  logic          aluexecCLK,
  input  logic          aluexecRSTN,
  input  logic          aluexecIV,
  output logic          aluexecRDY,
  input  logic [2:0]    aluexecOP,
  input  logic [DW-1:0] aluexecA,
  input  logic [DW-1:0] aluexecB,
  input  logic [AW-1:0] aluexecDST,
  output logic          aluexecWE,
  output logic [AW-1:0] aluexecWA,
  output logic [DW-1:0] aluexecWD,
  output logic          aluexecZ,
  output logic          aluexecC,
  output logic          aluexecERR
);

  localparam logic [2:0] OP_MUL = 3'b111;

  // Returns {flag, result}; the flag lands in the bit just above the result.
  function automatic logic [DW:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [2*DW-1:0] sh;
    logic [DW:0]     r;
    r  = '0;
    sh = '0;
    case (op)
      3'b000: r = {1'b0, a} + {1'b0, b};
      3'b001: r = {1'b0, a} - {1'b0, b};
      3'b010: r = {1'b0, a & b};
      3'b011: r = {1'b0, a | b};
      3'b100: r = {1'b0, a ^ b};
      3'b101: begin
        sh = {{DW{1'b0}}, a} << b[3:0];
        r  = {sh[DW], sh[DW-1:0]};
      end
      3'b110: begin
        sh = {a, {DW{1'b0}}} >> b[3:0];
        r  = {sh[DW-1], sh[2*DW-1:DW]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic dst_ok(input logic [AW-1:0] d);
    return int'(d) < NREG;
  endfunction

  logic          fire;
  logic          sc_fire;
  logic          sc_ok;
  logic [DW:0]   res_p0;

  assign fire   = aluexecIV && aluexecRDY;
  assign res_p0 = alu_f(aluexecOP, aluexecA, aluexecB);
  assign sc_ok  = dst_ok(aluexecDST) && (aluexecOP != OP_MUL);

`ifdef ALUEXEC_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t          state, state_nxt;
  logic [3:0]      cnt_p1;
  logic [2*DW-1:0] mcd_p1, acc_p1, acc_nxt;
  logic [DW-1:0]   mpl_p1;
  logic [AW-1:0]   dst_p1;
  logic            mul_last;

  assign sc_fire  = fire && (aluexecOP != OP_MUL);
  assign mul_last = (state == S_MUL) && (cnt_p1 == 4'(DW-1));
  assign acc_nxt  = acc_p1 + (mpl_p1[0] ? mcd_p1 : '0);

  always_comb begin
    state_nxt  = state;
    aluexecRDY = 1'b0;
    case (state)
      S_IDLE: begin
        aluexecRDY = 1'b1;
        if (aluexecIV && aluexecOP == OP_MUL) state_nxt = S_MUL;
      end
      S_MUL: if (cnt_p1 == 4'(DW-1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aluexecCLK) begin
    if (!aluexecRSTN) begin
      state  <= S_IDLE;
      cnt_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (fire) cnt_p1 <= '0;
      else if (state == S_MUL) cnt_p1 <= cnt_p1 + 4'd1;
    end
  end

  // Multiply datapath: one partial product folded in per cycle, no reset needed.
  always_ff @(posedge aluexecCLK) begin
    if (fire && aluexecOP == OP_MUL) begin
      mcd_p1 <= {{DW{1'b0}}, aluexecA};
      mpl_p1 <= aluexecB;
      acc_p1 <= '0;
      dst_p1 <= aluexecDST;
    end else if (state == S_MUL) begin
      acc_p1 <= acc_nxt;
      mcd_p1 <= mcd_p1 << 1;
      mpl_p1 <= mpl_p1 >> 1;
    end
  end
`else
  assign aluexecRDY = 1'b1;
  assign sc_fire    = fire;
`endif

  // Writeback stage: result, flags and the WE/ERR pulse.
  always_ff @(posedge aluexecCLK) begin
    if (!aluexecRSTN) begin
      aluexecWE  <= 1'b0;
      aluexecERR <= 1'b0;
      aluexecWA  <= '0;
      aluexecWD  <= '0;
      aluexecZ   <= 1'b0;
      aluexecC   <= 1'b0;
    end else begin
      aluexecWE  <= 1'b0;
      aluexecERR <= 1'b0;
      if (sc_fire) begin
        aluexecWA  <= aluexecDST;
        aluexecWD  <= res_p0[DW-1:0];
        aluexecZ   <= (res_p0[DW-1:0] == '0);
        aluexecC   <= res_p0[DW];
        aluexecWE  <= sc_ok;
        aluexecERR <= !sc_ok;
      end
`ifdef ALUEXEC_MUL_EN
      else if (mul_last) begin
        aluexecWA  <= dst_p1;
        aluexecWD  <= acc_nxt[DW-1:0];
        aluexecZ   <= (acc_nxt[DW-1:0] == '0);
        aluexecC   <= |acc_nxt[2*DW-1:DW];
        aluexecWE  <= dst_ok(dst_p1);
        aluexecERR <= !dst_ok(dst_p1);
      end
`endif
    end
  end

endmodule
